// File: rtl/fruit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fruit_arbiter_if
// Brief    : Requester handshakes, bowl level and bowl drive bundled for the arbiter
// Revision : 1.0
// ============================================================================
interface fruit_arbiter_if #(
  parameter int CNT_W = 3
);
  logic             apple_req;
  logic [CNT_W-1:0] apple_cnt;
  logic             apple_ack;
  logic             cherry_req;
  logic [CNT_W-1:0] cherry_cnt;
  logic             cherry_ack;
  logic [CNT_W-1:0] juice;
  logic             bowl_sel;
  logic             bowl_apple;
  logic             bowl_cherry;
  logic             busy;
  logic             owner;
  logic             done;

  modport master (
    output apple_req, apple_cnt, cherry_req, cherry_cnt, juice,
    input  apple_ack, cherry_ack, bowl_sel, bowl_apple, bowl_cherry, busy, owner, done
  );

  modport slave (
    input  apple_req, apple_cnt, cherry_req, cherry_cnt, juice,
    output apple_ack, cherry_ack, bowl_sel, bowl_apple, bowl_cherry, busy, owner, done
  );
endinterface
`default_nettype wire

// File: rtl/fruit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fruit_arbiter
// Brief    : Round-robin arbiter feeding the shared bowl one unit per cycle
// Revision : 1.0
// ============================================================================
module fruit_arbiter #(
  parameter int CNT_W = 3,
  parameter int CAP   = 7
) (
  input  wire logic      clk_i,
  input  wire logic      rst_ni,
  fruit_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_STALL = 2'd2
  } state_e;

  localparam logic [CNT_W:0]   CAP_L = CAP[CNT_W:0];
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ptr_q, ptr_d;       // 1 = apple has priority
  logic             owner_q, owner_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_c_q, ack_c_d;
  logic             done_q, done_d;
  logic             stb_a_q, stb_a_d;
  logic             stb_c_q, stb_c_d;
  logic             busy_q, busy_d;

  logic             grant_apple;
  logic [CNT_W-1:0] grant_cnt;
  logic [CNT_W:0]   level_in_flight;

  assign grant_apple = bus.apple_req & (~bus.cherry_req | ptr_q);
  assign grant_cnt   = grant_apple ? bus.apple_cnt : bus.cherry_cnt;

  // The bowl register lags a strobe by one cycle, so count the unit still in flight.
  assign level_in_flight = {1'b0, bus.juice} + {{CNT_W{1'b0}}, stb_a_q | stb_c_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    ack_a_d = 1'b0;
    ack_c_d = 1'b0;
    done_d  = 1'b0;
    stb_a_d = 1'b0;
    stb_c_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.apple_req | bus.cherry_req) begin
          owner_d = grant_apple;
          ptr_d   = ~grant_apple;
          rem_d   = grant_cnt;
          ack_a_d = grant_apple;
          ack_c_d = ~grant_apple;
          if (grant_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_FEED;
          end
        end
      end
      S_FEED: begin
        if (rem_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (level_in_flight < CAP_L) begin
          stb_a_d = owner_q;
          stb_c_d = ~owner_q;
          rem_d   = rem_q - ONE;
        end else begin
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        if ({1'b0, bus.juice} < CAP_L) begin
          state_d = S_FEED;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      ptr_q   <= 1'b1;
      owner_q <= 1'b0;
      ack_a_q <= 1'b0;
      ack_c_q <= 1'b0;
      done_q  <= 1'b0;
      stb_a_q <= 1'b0;
      stb_c_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      ack_a_q <= ack_a_d;
      ack_c_q <= ack_c_d;
      done_q  <= done_d;
      stb_a_q <= stb_a_d;
      stb_c_q <= stb_c_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.apple_ack   = ack_a_q;
  assign bus.cherry_ack  = ack_c_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;
  assign bus.bowl_sel    = owner_q;
  assign bus.bowl_apple  = stb_a_q;
  assign bus.bowl_cherry = stb_c_q;

endmodule
`default_nettype wire

// File: tb/tb_fruit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fruit_arbiter
// Brief    : Directed and randomized checks of fruit_arbiter against a bench model
// Revision : 1.0
// ============================================================================
module tb_fruit_arbiter;

  localparam int CNT_W = 3;
  localparam int CAP   = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fruit_arbiter_if #(.CNT_W(CNT_W)) bus ();

  fruit_arbiter #(.CNT_W(CNT_W), .CAP(CAP)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {bus.apple_ack, bus.cherry_ack, bus.done, bus.busy,
            bus.owner, bus.bowl_sel, bus.bowl_apple, bus.bowl_cherry};
  endfunction

  // Bowl: accumulates one unit per strobe, can be drained or forced to a level.
  bit bowl_set   = 1'b1;
  int bowl_val   = 0;
  int bowl_drain = 0;
  int bowl_nxt;
  bit bowl_over  = 1'b0;
  always @(posedge clk) begin
    bowl_nxt  = int'(bus.juice) + ((bus.bowl_apple || bus.bowl_cherry) ? 1 : 0);
    bowl_over = (bowl_nxt > CAP);
    if (bowl_set) bowl_nxt = bowl_val;
    else          bowl_nxt = (bowl_nxt > bowl_drain) ? bowl_nxt - bowl_drain : 0;
    bus.juice <= bowl_nxt[CNT_W-1:0];
  end

  // Behavioural model: a burst is just "units left", paused while the bowl is full.
  bit m_busy, m_wait, m_ptr_apple, m_owner, m_pick_apple, m_inflight;
  int m_left, m_units;
  bit e_ack_a, e_ack_c, e_done, e_strobe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_wait = 0; m_ptr_apple = 1; m_owner = 0;
      m_left = 0; m_units = 0;
      e_ack_a = 0; e_ack_c = 0; e_done = 0; e_strobe = 0;
    end else begin
      m_inflight = e_strobe;
      e_ack_a = 0; e_ack_c = 0; e_done = 0; e_strobe = 0;
      if (!m_busy) begin
        if (bus.apple_req || bus.cherry_req) begin
          m_pick_apple = bus.apple_req && (!bus.cherry_req || m_ptr_apple);
          m_owner      = m_pick_apple;
          m_ptr_apple  = !m_pick_apple;
          m_units      = m_pick_apple ? int'(bus.apple_cnt) : int'(bus.cherry_cnt);
          m_left       = m_units;
          e_ack_a      = m_pick_apple;
          e_ack_c      = !m_pick_apple;
          e_done       = (m_left == 0);
          m_busy       = (m_left != 0);
          m_wait       = 0;
        end
      end else if (m_wait) begin
        m_wait = !(int'(bus.juice) < CAP);
      end else if (m_left == 0) begin
        e_done = 1;
        m_busy = 0;
      end else if (int'(bus.juice) + int'(m_inflight) < CAP) begin
        e_strobe = 1;
        m_left--;
      end else begin
        m_wait = 1;
      end
    end
  end

  // Per-cycle comparison plus a burst-level unit count.
  logic [7:0] exp_v;
  int fed = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = {e_ack_a, e_ack_c, e_done, m_busy, m_owner, m_owner,
               e_strobe & m_owner, e_strobe & ~m_owner};
      check("outputs_vs_model", outs(), exp_v);
      check("bowl_level_le_cap", bowl_over, 0);
      if (!rst_n) begin
        fed = 0;
      end else begin
        if (bus.apple_ack || bus.cherry_ack) fed = 0;
        if (bus.bowl_apple || bus.bowl_cherry) fed++;
        if (bus.done) check("burst_units", fed, m_units);
      end
    end
  end

  task automatic do_reset;
    rst_n    = 0;
    bowl_val = 0;
    bowl_set = 1;
    step;
    step;
    rst_n    = 1;
    bowl_set = 0;
  endtask

  int  strobes, peak;
  bit  forced, seen_done;

  initial begin
    rst_n          = 0;
    bus.apple_req  = 0;
    bus.cherry_req = 0;
    bus.apple_cnt  = '0;
    bus.cherry_cnt = '0;
    repeat (3) step;
    chk_en = 1;
    check("reset_outputs", outs(), 0);
    rst_n    = 1;
    bowl_set = 0;

    // Apple alone, three units, empty bowl
    bus.apple_req = 1; bus.apple_cnt = 3'd3;
    step;
    check("t1_ack", {bus.apple_ack, bus.cherry_ack, bus.owner, bus.bowl_sel, bus.busy}, 5'b10111);
    bus.apple_req = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      check("t1_strobe", {bus.bowl_sel, bus.bowl_apple, bus.bowl_cherry, bus.done}, 4'b1100);
    end
    step;
    check("t1_done", {bus.done, bus.busy, bus.bowl_apple}, 3'b100);
    step;
    check("t1_idle", {bus.done, bus.busy}, 2'b00);

    // Both requesters, two units each, from reset
    do_reset;
    bus.apple_req = 1; bus.cherry_req = 1; bus.apple_cnt = 3'd2; bus.cherry_cnt = 3'd2;
    step;
    check("t2_ack_apple", {bus.apple_ack, bus.cherry_ack, bus.owner}, 3'b101);
    bus.apple_req = 0;
    step; check("t2_apple_1", {bus.bowl_apple, bus.bowl_cherry, bus.bowl_sel}, 3'b101);
    step; check("t2_apple_2", {bus.bowl_apple, bus.bowl_cherry, bus.bowl_sel}, 3'b101);
    step; check("t2_done_apple", {bus.done, bus.cherry_ack, bus.busy}, 3'b100);
    step; check("t2_ack_cherry", {bus.cherry_ack, bus.owner, bus.bowl_sel, bus.busy}, 4'b1001);
    bus.cherry_req = 0;
    step; check("t2_cherry_1", {bus.bowl_apple, bus.bowl_cherry, bus.bowl_sel}, 3'b010);
    step; check("t2_cherry_2", {bus.bowl_apple, bus.bowl_cherry, bus.bowl_sel}, 3'b010);
    step; check("t2_done_cherry", bus.done, 1);

    // Zero-unit apple request; pointer returns to apple, then moves to cherry
    bus.apple_req = 1; bus.apple_cnt = 3'd0; bus.cherry_req = 1; bus.cherry_cnt = 3'd1;
    step;
    check("t4_ack_done", {bus.apple_ack, bus.cherry_ack, bus.done, bus.busy,
                          bus.bowl_apple, bus.bowl_cherry}, 6'b101000);
    step;
    check("t4_ptr_cherry", {bus.apple_ack, bus.cherry_ack, bus.done, bus.owner}, 4'b0100);
    bus.cherry_req = 0;
    step; check("t6_hold_off", {bus.bowl_cherry, bus.apple_ack}, 2'b10);
    step; check("t6_done_no_ack", {bus.done, bus.apple_ack}, 2'b10);
    step; check("t6_apple_after", {bus.apple_ack, bus.done, bus.owner}, 3'b111);
    bus.apple_req = 0;
    step;

    // Cherry, four units, bowl starting at 5: stall at full, resume after drain
    do_reset;
    bowl_val = 5; bowl_set = 1;
    step;
    bowl_set = 0;
    bus.cherry_req = 1; bus.cherry_cnt = 3'd4;
    step;
    check("t3_ack", {bus.cherry_ack, bus.owner}, 2'b10);
    bus.cherry_req = 0;
    strobes = 0; peak = 0; forced = 0; seen_done = 0;
    for (int i = 0; i < 30 && !seen_done; i++) begin
      step;
      bowl_set = 0;
      if (bus.bowl_cherry) strobes++;
      if (int'(bus.juice) > peak) peak = int'(bus.juice);
      if (bus.done) seen_done = 1;
      if (bus.juice == 3'd7 && !forced) begin
        check("t3_units_before_full", strobes, 2);
        check("t3_stalled", {bus.busy, bus.bowl_cherry}, 2'b10);
        forced = 1; bowl_val = 3; bowl_set = 1;
      end
    end
    bowl_set = 0;
    check("t3_done_seen", seen_done, 1);
    check("t3_units", strobes, 4);
    check("t3_peak", peak, 7);

    // Reset in the middle of a five-unit apple burst
    do_reset;
    bus.apple_req = 1; bus.apple_cnt = 3'd5;
    step;
    bus.apple_req = 0;
    step;
    check("t5_first_strobe", bus.bowl_apple, 1);
    #2 rst_n = 0;
    #1 check("t5_async_clear", outs(), 0);
    step;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("t5_no_done", {bus.done, bus.busy}, 2'b00);
    end
    bus.cherry_req = 1; bus.cherry_cnt = 3'd1;
    step;
    check("t5_regrant", {bus.cherry_ack, bus.owner, bus.busy}, 3'b101);
    bus.cherry_req = 0;
    step; step; step;

    // Randomized traffic with a draining bowl
    for (int c = 0; c < 3000; c++) begin
      if (bus.apple_req && bus.apple_ack)             bus.apple_req = 0;
      else if (bus.apple_req && $urandom_range(0, 29) == 0) bus.apple_req = 0;
      else if (!bus.apple_req && $urandom_range(0, 3) == 0) begin
        bus.apple_req = 1;
        bus.apple_cnt = CNT_W'($urandom_range(0, 7));
      end
      if (bus.cherry_req && bus.cherry_ack)            bus.cherry_req = 0;
      else if (bus.cherry_req && $urandom_range(0, 29) == 0) bus.cherry_req = 0;
      else if (!bus.cherry_req && $urandom_range(0, 3) == 0) begin
        bus.cherry_req = 1;
        bus.cherry_cnt = CNT_W'($urandom_range(0, 7));
      end
      bowl_drain = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      step;
    end
    bus.apple_req = 0; bus.cherry_req = 0; bowl_drain = 0;
    repeat (20) step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fruit_arbiter.md
Name: fruit_arbiter

Overview:
- Controller that shares the single bowl accumulator datapath between two requesters, apple and cherry.
- Each requester asks for N fruit units. The arbiter grants round-robin, then drives the bowl's sel/apple/cherry inputs for one unit per cycle until N units are fed.
- It stalls feeding while the bowl level (juice) is at capacity, so the bowl never wraps.

Parameters:
- CNT_W, 3, width of request counts and of the bowl level.
- CAP, 7, bowl level at which feeding stalls; must be in 0 .. 2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- apple_req  input  1  apple requester holds high with apple_cnt stable until apple_ack.
- apple_cnt  input  CNT_W  units requested by apple.
- apple_ack  output  1  one-cycle pulse: apple request accepted.
- cherry_req  input  1  same as apple_req, for cherry.
- cherry_cnt  input  CNT_W  units requested by cherry.
- cherry_ack  output  1  one-cycle pulse: cherry request accepted.
- juice  input  CNT_W  current bowl level (registered in the bowl).
- bowl_sel  output  1  bowl select: 1 = apple path, 0 = cherry path.
- bowl_apple  output  1  apple unit strobe to the bowl.
- bowl_cherry  output  1  cherry unit strobe to the bowl.
- busy  output  1  high in FEED or STALL.
- owner  output  1  current or last grantee: 1 = apple, 0 = cherry.
- done  output  1  one-cycle pulse when a granted request completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, remaining=0, priority pointer=apple.
  - All outputs 0; bowl_sel=0, owner=0.
- States: IDLE, FEED, STALL. All outputs are registered.
- IDLE:
  - Only one requester high: grant it.
  - Both high: grant the pointer side.
  - On grant, in the same edge:
    - ack pulses for exactly 1 cycle in the next cycle.
    - owner and bowl_sel are set to the grantee.
    - remaining=cnt; pointer flips to the other side.
  - Next state after a grant:
    - cnt==0: IDLE, with done asserted together with the ack.
    - cnt>0: FEED.
  - No grant: pointer unchanged.
- FEED, per cycle:
  - juice<CAP: drive one strobe (bowl_apple if owner=1, else bowl_cherry) for this cycle and decrement remaining.
  - remaining reaches 0: done pulses in the cycle after the last strobe, then IDLE.
  - juice>=CAP: no strobe, go to STALL, remaining unchanged.
- STALL:
  - No strobes.
  - Return to FEED in the cycle after juice<CAP is observed.
- Strobe rules:
  - At most one strobe per cycle.
  - Strobes never asserted outside FEED.
  - bowl_sel is stable for the whole burst.
- Latency: first strobe in the cycle after the ack cycle; a burst of N units with no stalls spans N cycles.
- Level overshoot: the bowl updates one cycle after a strobe, so the level may reach CAP+1 at most.
  - With CAP = 2^CNT_W-1 this would wrap.
  - Therefore the juice>=CAP test uses juice+1 in flight: no strobe is issued if the previous cycle strobed and juice==CAP-1.
- Requests arriving during FEED/STALL are held off (no ack) until return to IDLE. A grant may occur in the first IDLE cycle after done.
- Requester dropping req before ack: no grant; no error.
- Reset mid-burst: abandons the burst immediately; no done pulse.

Test Plan:
- Apple only, apple_cnt=3, juice=0 held:
  - Expected: apple_ack 1 cycle, then bowl_sel=1 with bowl_apple high 3 consecutive cycles, done 1 cycle, busy low after.
- Both req, cnt=2 each, from reset:
  - Expected: apple granted first (pointer=apple), 2 apple strobes.
  - Then cherry acked, bowl_sel=0, 2 cherry strobes.
  - Pointer back to apple.
- Cherry cnt=4, bowl model reset to level 5, CAP=7:
  - Expected: strobes 1 and 2 issued, level reaches 7, STALL.
  - Force level to 3: feeding resumes, 2 more strobes, done.
  - Level never exceeds 7.
- apple_cnt=0:
  - Expected: ack and done in the same cycle, no strobes, state IDLE next cycle, pointer=cherry.
- Reset asserted mid-burst (after 1 of 5 strobes):
  - Expected: all outputs 0 immediately (async), no done.
  - After release, a new request is granted normally.
- Cherry req raised during an apple burst:
  - Expected: no cherry_ack until the cycle after apple done; then cherry is granted.
